// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: stall counter sizing,
// lock-state encoding and the wrapped index increment.
package fifo_arb_pkg;

  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

  // Burst lock state, only used when ARB_LOCK_EN is defined.
  typedef enum logic {
    LK_OPEN   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  // Increment idx modulo n (n need not be a power of two).
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-facing bundle for fifo_wr_arbiter.
// Handshake: a requester raises req[i] with wdata/last stable and holds them
// until ack[i] is seen high in a cycle; that cycle's rising edge completes the
// beat. fifo_wr/fifo_wdata mirror the accepted beat in the same cycle. Dropping
// req before ack withdraws the beat. dbg_* expose the internal arbitration state.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            last;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [IDX_W-1:0]              grant_idx;
  logic [IDX_W-1:0]              dbg_ptr;
  logic                          dbg_lock_vld;
  logic [IDX_W-1:0]              dbg_lock_idx;

  modport master (
    output req, wdata, last, fifo_full,
    input  ack, fifo_wr, fifo_wdata, grant_idx,
    input  dbg_ptr, dbg_lock_vld, dbg_lock_idx
  );

  modport slave (
    input  req, wdata, last, fifo_full,
    output ack, fifo_wr, fifo_wdata, grant_idx,
    output dbg_ptr, dbg_lock_vld, dbg_lock_idx
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Cyclic priority search: first set bit of eligible at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk N positions starting at ptr; the first hit wins.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && eligible[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers.
// Zero-latency combinational grant; never writes while fifo_full; counts stalled
// cycles. Optional burst locking is enabled by defining ARB_LOCK_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_wr_arbiter_if.slave      bus,
  input  logic                  stall_clr,
  output logic [STALL_W-1:0]    stall_cnt
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] base_elig, eligible;
  logic               found, accept;
  logic [IDX_W-1:0]   pick_idx;

  assign base_elig = bus.req & ~{NUM_REQ{bus.fifo_full}};

`ifdef ARB_LOCK_EN
  lock_state_e      state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  // While a burst holds the lock, only its owner may be picked.
  always_comb begin
    eligible = base_elig;
    if (state_q == LK_LOCKED) eligible = base_elig & (NUM_REQ'(1) << lock_idx_q);
  end
`else
  assign eligible = base_elig;
`endif

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (found),
    .idx      (pick_idx)
  );

  // Reset masks the combinational write path so nothing leaks out during reset.
  assign accept = found & ~reset;

  // Write path: one-hot ack and data mux for the winner, all zero when idle.
  always_comb begin
    bus.ack        = '0;
    bus.fifo_wr    = 1'b0;
    bus.fifo_wdata = '0;
    bus.grant_idx  = '0;
    if (accept) begin
      bus.ack        = NUM_REQ'(1) << pick_idx;
      bus.fifo_wr    = 1'b1;
      bus.fifo_wdata = bus.wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
      bus.grant_idx  = pick_idx;
    end
  end

`ifdef ARB_LOCK_EN
  // Lock next-state: a non-last beat from an open arbiter takes the lock;
  // the owner's last beat releases it and moves ptr past the owner.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    case (state_q)
      LK_OPEN: begin
        if (accept) begin
          if (bus.last[pick_idx]) begin
            ptr_d = IDX_W'(next_idx(int'(pick_idx), NUM_REQ));
          end else begin
            state_d    = LK_LOCKED;
            lock_idx_d = pick_idx;
          end
        end
      end
      LK_LOCKED: begin
        if (accept && bus.last[pick_idx]) begin
          state_d = LK_OPEN;
          ptr_d   = IDX_W'(next_idx(int'(lock_idx_q), NUM_REQ));
        end
      end
      default: state_d = LK_OPEN;
    endcase
  end

  // Lock state and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LK_OPEN;
      lock_idx_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.dbg_lock_vld = (state_q == LK_LOCKED);
  assign bus.dbg_lock_idx = lock_idx_q;
`else
  // Every beat re-arbitrates; last has no effect in this build.
  logic unused_last;
  assign unused_last = ^bus.last;

  // Advance ptr past the winner; hold when nothing is written.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = IDX_W'(next_idx(int'(pick_idx), NUM_REQ));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign bus.dbg_lock_vld = 1'b0;
  assign bus.dbg_lock_idx = '0;
`endif

  assign bus.dbg_ptr = ptr_q;

  // Saturating count of cycles where someone wants to write but the FIFO is full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if ((|bus.req) && bus.fifo_full && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table for the 4-requester
// instance, hand sequences for bursts and reset, and a 3-requester instance.
module tb_fifo_wr_arbiter;

  logic clk;
  logic reset;
  logic clr4, clr3;
  logic [15:0] stall4, stall3;

  int tests_run    = 0;
  int tests_failed = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus4 ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) bus3 ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus4),
    .stall_clr (clr4),
    .stall_cnt (stall4)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus3),
    .stall_clr (clr3),
    .stall_cnt (stall3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic        clr;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] req, input logic full, input logic clr,
                         input logic [3:0] ack, input logic [1:0] g,
                         input logic [7:0] d, input logic [15:0] s);
    vec_t v;
    v.req = req; v.full = full; v.clr = clr;
    v.exp_ack = ack; v.exp_grant = g; v.exp_data = d; v.exp_stall = s;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus4.req = '0; bus4.fifo_full = 1'b0; bus4.last = '1; clr4 = 1'b0;
    bus3.req = '0; bus3.fifo_full = 1'b0; bus3.last = '1; clr3 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int beats;
    int exp_g[$];

    bus4.wdata = 32'hA3A2A1A0;
    bus3.wdata = 24'hC2C1C0;
    do_reset();

    // Reset state of both instances
    check("rst_ptr4", 32'(bus4.dbg_ptr), 0);
    check("rst_stall4", 32'(stall4), 0);
    check("rst_lock4", 32'(bus4.dbg_lock_vld), 0);
    check("rst_ptr3", 32'(bus3.dbg_ptr), 0);

    // Rotation over all four
    for (int i = 0; i < 8; i++)
      add_vec(4'hF, 1'b0, 1'b0, 4'(1 << (i % 4)), 2'(i % 4), 8'(8'hA0 + (i % 4)), 16'd0);
    // Sparse requests 0 and 2
    add_vec(4'b0101, 0, 0, 4'b0001, 2'd0, 8'hA0, 16'd0);
    add_vec(4'b0101, 0, 0, 4'b0100, 2'd2, 8'hA2, 16'd0);
    add_vec(4'b0101, 0, 0, 4'b0001, 2'd0, 8'hA0, 16'd0);
    add_vec(4'b0101, 0, 0, 4'b0100, 2'd2, 8'hA2, 16'd0);
    // Full stalls requester 1 for five cycles
    for (int i = 0; i < 5; i++)
      add_vec(4'b0010, 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 16'(i));
    add_vec(4'b0010, 0, 0, 4'b0010, 2'd1, 8'hA1, 16'd5);
    add_vec(4'b0000, 0, 1, 4'b0000, 2'd0, 8'h00, 16'd5);
    add_vec(4'b0000, 0, 0, 4'b0000, 2'd0, 8'h00, 16'd0);
    // Full with all requesting, then full with no request (no count)
    add_vec(4'hF,    1, 0, 4'b0000, 2'd0, 8'h00, 16'd0);
    add_vec(4'b0000, 1, 0, 4'b0000, 2'd0, 8'h00, 16'd1);
    // Wrapping search from ptr=2
    add_vec(4'b0001, 0, 0, 4'b0001, 2'd0, 8'hA0, 16'd1);
    add_vec(4'b1000, 0, 0, 4'b1000, 2'd3, 8'hA3, 16'd1);
    add_vec(4'b1100, 0, 1, 4'b0100, 2'd2, 8'hA2, 16'd1);
    add_vec(4'b1100, 0, 0, 4'b1000, 2'd3, 8'hA3, 16'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus4.req = vecs[i].req;
      bus4.fifo_full = vecs[i].full;
      clr4 = vecs[i].clr;
      bus4.last = '1;
      #2;
      check($sformatf("v%0d_ack", i), 32'(bus4.ack), 32'(vecs[i].exp_ack));
      check($sformatf("v%0d_wr", i), 32'(bus4.fifo_wr), 32'(|vecs[i].exp_ack));
      check($sformatf("v%0d_grant", i), 32'(bus4.grant_idx), 32'(vecs[i].exp_grant));
      check($sformatf("v%0d_data", i), 32'(bus4.fifo_wdata), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_stall", i), 32'(stall4), 32'(vecs[i].exp_stall));
    end

    // Three-beat burst from requester 0 while requester 1 keeps asking
    do_reset();
`ifdef ARB_LOCK_EN
    exp_g = '{0, 0, 0, 1};
`else
    exp_g = '{0, 1, 0, 1, 0};
`endif
    beats = 3;
    foreach (exp_g[k]) begin
      @(negedge clk);
      bus4.req  = {2'b00, 1'b1, (beats > 0)};
      bus4.last = {3'b111, (beats == 1)};
      #2;
      check($sformatf("burst%0d_wr", k), 32'(bus4.fifo_wr), 1);
      check($sformatf("burst%0d_grant", k), 32'(bus4.grant_idx), 32'(exp_g[k]));
      if (bus4.ack[0]) beats--;
    end
    check("burst_done", 32'(beats), 0);

    // Three requesters: pointer wraps at 2
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus3.req = 3'b111;
      #2;
      check($sformatf("n3_%0d_grant", k), 32'(bus3.grant_idx), 32'(k % 3));
      check($sformatf("n3_%0d_ack", k), 32'(bus3.ack), 32'(1 << (k % 3)));
      check($sformatf("n3_%0d_ptr_range", k), 32'(bus3.dbg_ptr < 2'd3), 1);
    end
    bus3.req = '0;

    // Reset in the middle of a burst with a nonzero stall count
    do_reset();
    @(negedge clk);
    bus4.req = 4'b0010; bus4.last = 4'hF;
    #2;
    check("mid_g1", 32'(bus4.grant_idx), 1);
    @(negedge clk);
    bus4.req = 4'b0100; bus4.last = 4'h0;
    #2;
    check("mid_g2", 32'(bus4.grant_idx), 2);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus4.fifo_full = 1'b1;
    end
    @(negedge clk);
    #2;
    check("mid_stall7", 32'(stall4), 7);
    check("mid_full_ack", 32'(bus4.ack), 0);
`ifdef ARB_LOCK_EN
    check("mid_lock", 32'(bus4.dbg_lock_vld), 1);
    check("mid_ptr2", 32'(bus4.dbg_ptr), 2);
`endif
    bus4.fifo_full = 1'b0;
    #1;
    reset = 1'b1;
    bus4.req = 4'hF;
    #1;
    check("inrst_ack", 32'(bus4.ack), 0);
    check("inrst_wr", 32'(bus4.fifo_wr), 0);
    check("inrst_data", 32'(bus4.fifo_wdata), 0);
    check("inrst_grant", 32'(bus4.grant_idx), 0);
    check("inrst_stall", 32'(stall4), 0);
    check("inrst_lock", 32'(bus4.dbg_lock_vld), 0);
    @(negedge clk);
    reset = 1'b0;
    bus4.last = 4'hF;
    #2;
    check("post_grant", 32'(bus4.grant_idx), 0);
    check("post_ack", 32'(bus4.ack), 1);
    check("post_stall", 32'(stall4), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
